// File: rtl/wb_align_stage_if.sv
// Bus bundle between the MEM/WB pipeline register, data memory return path and
// the register-file write port of wb_align_stage.
interface wb_align_stage_if #(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
);
   localparam int LANE_W = $clog2(XLEN / 8);

   logic                 PIP_valid_i;
   logic                 PIP_ready_o;
   logic                 PIP_use_mem_i;
   logic                 PIP_write_reg_i;
   logic [2:0]           PIP_funct3_i;
   logic [LANE_W-1:0]    PIP_addr_lo_i;
   logic [XLEN-1:0]      PIP_alu_result_i;
   logic [RF_ADDR_W-1:0] PIP_rd_i;
   logic                 PIP_TRAP_i;
   logic                 DMEM_rvalid_i;
   logic [XLEN-1:0]      DMEM_rdata_i;
   logic                 REG_write_o;
   logic [XLEN-1:0]      REG_data_o;
   logic [RF_ADDR_W-1:0] REG_addr_o;
   logic                 PIP_TRAP_o;

   modport master (
      output PIP_valid_i, PIP_use_mem_i, PIP_write_reg_i, PIP_funct3_i,
             PIP_addr_lo_i, PIP_alu_result_i, PIP_rd_i, PIP_TRAP_i,
             DMEM_rvalid_i, DMEM_rdata_i,
      input  PIP_ready_o, REG_write_o, REG_data_o, REG_addr_o, PIP_TRAP_o
   );

   modport slave (
      input  PIP_valid_i, PIP_use_mem_i, PIP_write_reg_i, PIP_funct3_i,
             PIP_addr_lo_i, PIP_alu_result_i, PIP_rd_i, PIP_TRAP_i,
             DMEM_rvalid_i, DMEM_rdata_i,
      output PIP_ready_o, REG_write_o, REG_data_o, REG_addr_o, PIP_TRAP_o
   );
endinterface

// File: rtl/wb_align_stage.sv
// Write-back stage: waits for load data when needed, aligns/extends it and
// issues a registered one-cycle register-file write or trap retire pulse.
module wb_align_stage #(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   wb_align_stage_if.slave   bus,
   output logic              stall_o,
   output logic [31:0]       wb_count_o
);
   localparam int LANE_W = $clog2(XLEN / 8);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t               state_q, state_d;
   logic [RF_ADDR_W-1:0] rd_q;
   logic [2:0]           funct3_q;
   logic [LANE_W-1:0]    addr_lo_q;
   logic                 write_reg_q;
   logic                 trap_q;
   logic [31:0]          wb_count_q;

   logic                 accept;
   logic                 fire;
   logic                 latch_load;
   logic                 commit;
   logic [RF_ADDR_W-1:0] sel_rd;
   logic [2:0]           sel_funct3;
   logic [LANE_W-1:0]    sel_addr_lo;
   logic                 sel_write_reg;
   logic                 sel_trap;
   logic                 sel_use_mem;
   logic [XLEN-1:0]      load_data;
   logic [XLEN-1:0]      sel_data;
   logic [LANE_W+2:0]    sh_b, sh_h, sh_w;
   logic [7:0]           byte_v;
   logic [15:0]          half_v;
   logic [31:0]          word_v;

   assign bus.PIP_ready_o = (state_q == IDLE);
   assign stall_o         = (state_q != IDLE);
   assign accept          = bus.PIP_valid_i & bus.PIP_ready_o;
   assign wb_count_o      = wb_count_q;

   // Fields come straight from the pipeline when the write fires in the accept
   // cycle, and from the latched copy when it fires out of WAIT_MEM.
   always_comb begin
      state_d       = state_q;
      fire          = 1'b0;
      latch_load    = 1'b0;
      sel_rd        = rd_q;
      sel_funct3    = funct3_q;
      sel_addr_lo   = addr_lo_q;
      sel_write_reg = write_reg_q;
      sel_trap      = trap_q;
      sel_use_mem   = 1'b1;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sel_rd        = bus.PIP_rd_i;
               sel_funct3    = bus.PIP_funct3_i;
               sel_addr_lo   = bus.PIP_addr_lo_i;
               sel_write_reg = bus.PIP_write_reg_i;
               sel_trap      = bus.PIP_TRAP_i;
               sel_use_mem   = bus.PIP_use_mem_i;
               if (!bus.PIP_use_mem_i || bus.DMEM_rvalid_i) begin
                  fire = 1'b1;
               end else begin
                  latch_load = 1'b1;
                  state_d    = WAIT_MEM;
               end
            end
         end
         WAIT_MEM: begin
            if (bus.DMEM_rvalid_i) begin
               fire    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sh_b   = {sel_addr_lo, 3'b000};
      sh_h   = {sel_addr_lo & ~LANE_W'(1), 3'b000};
      sh_w   = {sel_addr_lo & ~LANE_W'(3), 3'b000};
      byte_v = 8'(bus.DMEM_rdata_i >> sh_b);
      half_v = 16'(bus.DMEM_rdata_i >> sh_h);
      word_v = 32'(bus.DMEM_rdata_i >> sh_w);
      case (sel_funct3)
         3'b000:  load_data = XLEN'($signed(byte_v));
         3'b100:  load_data = XLEN'(byte_v);
         3'b001:  load_data = XLEN'($signed(half_v));
         3'b101:  load_data = XLEN'(half_v);
         3'b010:  load_data = XLEN'($signed(word_v));
         3'b110:  load_data = XLEN'(word_v);
         default: load_data = bus.DMEM_rdata_i;
      endcase
      sel_data = sel_use_mem ? load_data : bus.PIP_alu_result_i;
   end

   assign commit = fire & sel_write_reg & (sel_rd != '0) & ~sel_trap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         rd_q            <= '0;
         funct3_q        <= '0;
         addr_lo_q       <= '0;
         write_reg_q     <= 1'b0;
         trap_q          <= 1'b0;
         bus.REG_write_o <= 1'b0;
         bus.REG_data_o  <= '0;
         bus.REG_addr_o  <= '0;
         bus.PIP_TRAP_o  <= 1'b0;
         wb_count_q      <= '0;
      end else begin
         state_q         <= state_d;
         bus.REG_write_o <= commit;
         bus.PIP_TRAP_o  <= fire & sel_trap;
         if (latch_load) begin
            rd_q        <= bus.PIP_rd_i;
            funct3_q    <= bus.PIP_funct3_i;
            addr_lo_q   <= bus.PIP_addr_lo_i;
            write_reg_q <= bus.PIP_write_reg_i;
            trap_q      <= bus.PIP_TRAP_i;
         end
         // Counter advances on the same edge that raises REG_write_o.
         if (commit) begin
            bus.REG_data_o <= sel_data;
            bus.REG_addr_o <= sel_rd;
            wb_count_q     <= wb_count_q + 32'd1;
         end
      end
   end
endmodule
